dm_cache_flush: RTL



---
 rtl/dm_cache_flush.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dm_cache_flush.sv
// Flush engine for the direct-mapped cache: walks every index, writes valid+dirty
// lines back to memory and clears their dirty bit in the tag store.
module dm_cache_flush #(
  parameter int NUM_LINES = 1024,
  parameter int INDEX_W   = 10,
  parameter int TAG_W     = 18,
  parameter int LINE_W    = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_start,
  output logic               flush_busy,
  output logic               flush_done,
  output logic [INDEX_W-1:0] tag_req_index,
  output logic               tag_req_we,
  output logic [TAG_W+1:0]   tag_write,
  input  logic [TAG_W+1:0]   tag_read,
  output logic [INDEX_W-1:0] data_req_index,
  output logic               data_req_we,
  input  logic [LINE_W-1:0]  data_read,
  output logic [31:0]        mem_req_addr,
  output logic [LINE_W-1:0]  mem_req_data,
  output logic               mem_req_rw,
  output logic               mem_req_valid,
  input  logic               mem_ready
);

  typedef enum logic [2:0] {IDLE, CHECK, WRITEBACK, CLEAN, DONE} state_t;

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(NUM_LINES - 1);

  state_t              state_reg, state_next;
  logic [INDEX_W-1:0]  idx_reg, idx_next;
  logic [TAG_W-1:0]    tag_reg, tag_next;
  logic [31:0]         addr_reg, addr_next;
  logic [LINE_W-1:0]   data_reg, data_next;
  logic                rw_reg, rw_next;
  logic                valid_reg, valid_next;

  logic                line_valid, line_dirty;
  logic [TAG_W-1:0]    line_tag;

  assign line_valid = tag_read[TAG_W+1];
  assign line_dirty = tag_read[TAG_W];
  assign line_tag   = tag_read[TAG_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      tag_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      rw_reg    <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      tag_reg   <= tag_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      rw_reg    <= rw_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    tag_next   = tag_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    rw_next    = rw_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        if (flush_start) begin
          idx_next   = '0;
          state_next = CHECK;
        end
      end
      CHECK: begin
        // Invalid lines are skipped even when their dirty bit is set.
        if (line_valid && line_dirty) begin
          addr_next  = 32'({line_tag, idx_reg, 4'b0000});
          data_next  = data_read;
          tag_next   = line_tag;
          rw_next    = 1'b1;
          valid_next = 1'b1;
          state_next = WRITEBACK;
        end else if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          valid_next = 1'b0;
          state_next = CLEAN;
        end
      end
      CLEAN: begin
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = CHECK;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    flush_busy     = (state_reg != IDLE);
    flush_done     = (state_reg == DONE);
    tag_req_index  = idx_reg;
    data_req_index = idx_reg;
    tag_req_we     = (state_reg == CLEAN);
    tag_write      = {1'b1, 1'b0, tag_reg};
    data_req_we    = 1'b0;
    mem_req_addr   = addr_reg;
    mem_req_data   = data_reg;
    mem_req_rw     = rw_reg;
    mem_req_valid  = valid_reg;
  end

endmodule
